// File: rtl/triangle_wave_analyzer_pkg.sv
// Shared constants for the triangle-wave receive path: slope encoding
// (matches the generator's dir output) and analyzer FSM states.
package triangle_wave_analyzer_pkg;

  localparam logic SLOPE_UP   = 1'b0;
  localparam logic SLOPE_DOWN = 1'b1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_RISE  = 2'd2;
  localparam logic [1:0] ST_FALL  = 2'd3;

endpackage

// File: rtl/triangle_wave_analyzer_slope_cmp.sv
// Combinational sample-vs-previous comparator: ordering plus an illegal
// step flag computed on a WIDTH+1 bit magnitude so nothing wraps.
module triangle_slope_cmp #(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 1
) (
  input  logic [WIDTH-1:0] sample_i,
  input  logic [WIDTH-1:0] prev_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             step_too_big_o
);

  logic [WIDTH:0] diff_s;

  // Magnitude of the step between consecutive samples
  always_comb begin
    gt_o = (sample_i > prev_i);
    lt_o = (sample_i < prev_i);
    if (gt_o) begin
      diff_s = {1'b0, sample_i} - {1'b0, prev_i};
    end else begin
      diff_s = {1'b0, prev_i} - {1'b0, sample_i};
    end
    step_too_big_o = (diff_s > (WIDTH + 1)'(MAX_STEP));
  end

endmodule

// File: rtl/triangle_wave_analyzer.sv
// Recovers trough, peak and trough-to-trough period (in accepted samples)
// from a sampled triangle/ramp stream; one result per completed period.
module triangle_wave_analyzer
  import triangle_wave_analyzer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int MAX_STEP     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        sample_in,
  input  logic                    sample_valid,
  output logic [WIDTH-1:0]        meas_low,
  output logic [WIDTH-1:0]        meas_high,
  output logic [PERIOD_WIDTH-1:0] meas_period,
  output logic                    meas_valid,
  output logic                    step_err,
  output logic                    locked
);

  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = {PERIOD_WIDTH{1'b1}};
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [WIDTH-1:0]        peak_q, peak_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    have_peak_q, have_peak_d;
  logic                    have_trough_q, have_trough_d;
  logic [WIDTH-1:0]        meas_low_q, meas_low_d;
  logic [WIDTH-1:0]        meas_high_q, meas_high_d;
  logic [PERIOD_WIDTH-1:0] meas_period_q, meas_period_d;
  logic                    meas_valid_q, meas_valid_d;
  logic                    step_err_q, step_err_d;
  logic                    locked_q, locked_d;

  logic                    gt_s, lt_s, step_too_big_s;
  logic [PERIOD_WIDTH-1:0] cnt_inc_s;

  triangle_slope_cmp #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP)
  ) u_cmp (
    .sample_i       (sample_in),
    .prev_i         (prev_q),
    .gt_o           (gt_s),
    .lt_o           (lt_s),
    .step_too_big_o (step_too_big_s)
  );

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state: slope FSM, turn capture and period counting
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    peak_d        = peak_q;
    cnt_d         = cnt_q;
    have_peak_d   = have_peak_q;
    have_trough_d = have_trough_q;
    meas_low_d    = meas_low_q;
    meas_high_d   = meas_high_q;
    meas_period_d = meas_period_q;
    meas_valid_d  = 1'b0;
    step_err_d    = 1'b0;
    locked_d      = locked_q;
    if (sample_valid) begin
      prev_d = sample_in;
      if (state_q == ST_EMPTY) begin
        cnt_d   = CNT_ONE;
        state_d = ST_ACQ;
      end else if (step_too_big_s) begin
        // Step check wins over any turn revealed by the same sample
        step_err_d    = 1'b1;
        locked_d      = 1'b0;
        have_peak_d   = 1'b0;
        have_trough_d = 1'b0;
        cnt_d         = CNT_ONE;
        state_d       = ST_ACQ;
      end else begin
        cnt_d = cnt_inc_s;
        case (state_q)
          ST_ACQ: begin
            if (gt_s) begin
              state_d = ST_RISE;
            end else if (lt_s) begin
              state_d = ST_FALL;
            end else begin
              state_d = ST_ACQ;
            end
          end
          ST_RISE: begin
            if (lt_s) begin
              peak_d      = prev_q;
              have_peak_d = 1'b1;
              state_d     = ST_FALL;
            end else begin
              state_d = ST_RISE;
            end
          end
          ST_FALL: begin
            if (gt_s) begin
              if (have_trough_q && have_peak_q) begin
                meas_low_d    = prev_q;
                meas_high_d   = peak_q;
                meas_period_d = cnt_q;
                meas_valid_d  = 1'b1;
                locked_d      = 1'b1;
              end else begin
                meas_valid_d = 1'b0;
              end
              have_trough_d = 1'b1;
              have_peak_d   = 1'b0;
              cnt_d         = CNT_ONE;
              state_d       = ST_RISE;
            end else begin
              state_d = ST_FALL;
            end
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      prev_q        <= '0;
      peak_q        <= '0;
      cnt_q         <= '0;
      have_peak_q   <= 1'b0;
      have_trough_q <= 1'b0;
      meas_low_q    <= '0;
      meas_high_q   <= '0;
      meas_period_q <= '0;
      meas_valid_q  <= 1'b0;
      step_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      peak_q        <= peak_d;
      cnt_q         <= cnt_d;
      have_peak_q   <= have_peak_d;
      have_trough_q <= have_trough_d;
      meas_low_q    <= meas_low_d;
      meas_high_q   <= meas_high_d;
      meas_period_q <= meas_period_d;
      meas_valid_q  <= meas_valid_d;
      step_err_q    <= step_err_d;
      locked_q      <= locked_d;
    end
  end

  assign meas_low    = meas_low_q;
  assign meas_high   = meas_high_q;
  assign meas_period = meas_period_q;
  assign meas_valid  = meas_valid_q;
  assign step_err    = step_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_triangle_wave_analyzer.sv
// Self-checking bench: vector table for the degenerate stream, hand-written
// corner sequences, and randomized streams against a history-based model.
module tb_triangle_wave_analyzer;

  localparam int WIDTH    = 8;
  localparam int PW       = 16;
  localparam int MAX_STEP = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [WIDTH-1:0] sample_in = '0;
  logic            sample_valid = 1'b0;
  logic [WIDTH-1:0] meas_low, meas_high;
  logic [PW-1:0]   meas_period;
  logic            meas_valid, step_err, locked;

  int n_checks = 0;
  int n_errors = 0;

  triangle_wave_analyzer #(.WIDTH(WIDTH), .PERIOD_WIDTH(PW), .MAX_STEP(MAX_STEP)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .meas_low(meas_low), .meas_high(meas_high), .meas_period(meas_period),
    .meas_valid(meas_valid), .step_err(step_err), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: history of accepted samples since last reset/step error;
  // turns are found by searching the history for the last non-flat slope.
  int hist[$];
  int last_trough_rev, last_peak_rev, last_peak_val;
  int m_low, m_high, m_period, m_mv, m_err, m_locked;

  task automatic model_reset();
    hist.delete();
    last_trough_rev = -1; last_peak_rev = -1; last_peak_val = 0;
    m_low = 0; m_high = 0; m_period = 0; m_mv = 0; m_err = 0; m_locked = 0;
  endtask

  task automatic model_accept(input int s);
    int last, dir, n, d;
    m_mv = 0; m_err = 0;
    if (hist.size() == 0) begin
      hist.push_back(s);
      return;
    end
    last = hist[hist.size()-1];
    d = (s > last) ? s - last : last - s;
    if (d > MAX_STEP) begin
      m_err = 1; m_locked = 0;
      hist.delete(); hist.push_back(s);
      last_trough_rev = -1; last_peak_rev = -1;
      return;
    end
    dir = 0;
    for (int i = hist.size() - 1; i > 0; i--) begin
      if (hist[i] != hist[i-1]) begin
        dir = (hist[i] > hist[i-1]) ? 1 : -1;
        break;
      end
    end
    n = hist.size();
    if (s > last && dir < 0) begin
      if (last_trough_rev >= 0 && last_peak_rev > last_trough_rev) begin
        m_mv = 1; m_low = last; m_high = last_peak_val;
        m_period = (n - last_trough_rev > 65535) ? 65535 : n - last_trough_rev;
        m_locked = 1;
      end
      last_trough_rev = n;
    end
    if (s < last && dir > 0) begin
      last_peak_rev = n; last_peak_val = last;
    end
    hist.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("meas_valid", 32'(meas_valid), 32'(m_mv));
    check("step_err", 32'(step_err), 32'(m_err));
    check("locked", 32'(locked), 32'(m_locked));
    check("meas_low", 32'(meas_low), 32'(m_low));
    check("meas_high", 32'(meas_high), 32'(m_high));
    check("meas_period", 32'(meas_period), 32'(m_period));
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] s);
    @(negedge clk);
    sample_valid = v; sample_in = s;
    @(posedge clk); #1;
    if (v) model_accept(int'(s));
    else begin m_mv = 0; m_err = 0; end
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_step_err", 32'(step_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_meas_low", 32'(meas_low), 32'd0);
    check("rst_meas_high", 32'(meas_high), 32'd0);
    check("rst_meas_period", 32'(meas_period), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       mv;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [15:0] per;
    logic       err;
    logic       lk;
  } vec_t;

  vec_t tbl[8];

  task automatic tri_next(inout int t, inout int up, input int lo, input int hi);
    if (up != 0) begin
      if (t >= hi) begin up = 0; t = t - 1; end else t = t + 1;
    end else begin
      if (t <= lo) begin up = 1; t = t + 1; end else t = t - 1;
    end
  endtask

  initial begin
    int t, up, meas_cnt, cur, r;
    int flat_seq[16];
    model_reset();

    tbl[0] = '{1'b1, 8'd3, 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'd2, 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'd3, 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'd2, 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'd3, 1'b1, 8'd2, 8'd3, 16'd2, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'd9, 1'b0, 8'd2, 8'd3, 16'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'd2, 1'b0, 8'd2, 8'd3, 16'd2, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'd3, 1'b1, 8'd2, 8'd3, 16'd2, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Degenerate 3,2,3,2 stream from the vector table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].s);
      check("tbl_meas_valid", 32'(meas_valid), 32'(tbl[i].mv));
      check("tbl_meas_low", 32'(meas_low), 32'(tbl[i].lo));
      check("tbl_meas_high", 32'(meas_high), 32'(tbl[i].hi));
      check("tbl_meas_period", 32'(meas_period), 32'(tbl[i].per));
      check("tbl_step_err", 32'(step_err), 32'(tbl[i].err));
      check("tbl_locked", 32'(locked), 32'(tbl[i].lk));
    end

    // low=2 high=5, valid every cycle: first result on the 14th sample
    do_reset();
    t = 2; up = 1; meas_cnt = 0;
    for (int i = 1; i <= 26; i++) begin
      drive(1'b1, 8'(t));
      if (i == 14 || i == 20 || i == 26) begin
        check("tri_mv_at_turn", 32'(meas_valid), 32'd1);
        check("tri_low", 32'(meas_low), 32'd2);
        check("tri_high", 32'(meas_high), 32'd5);
        check("tri_period", 32'(meas_period), 32'd6);
      end else if (i < 14) begin
        check("tri_no_early_mv", 32'(meas_valid), 32'd0);
      end
      tri_next(t, up, 2, 5);
    end

    // Same stream with ~50% valid: period counts samples, not cycles
    do_reset();
    t = 2; up = 1; meas_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 8'(t));
        tri_next(t, up, 2, 5);
      end else begin
        drive(1'b0, 8'($urandom_range(0, 255)));
      end
      if (m_mv != 0) begin
        meas_cnt++;
        check("gap_period", 32'(meas_period), 32'd6);
        check("gap_high", 32'(meas_high), 32'd5);
      end
    end
    check("gap_some_meas", 32'(meas_cnt > 3), 32'd1);

    // Flat top 5,5,5 at the peak
    do_reset();
    flat_seq = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 5, 5, 4, 3, 2, 3};
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(flat_seq[i]));
    check("flat_mv", 32'(meas_valid), 32'd1);
    check("flat_high", 32'(meas_high), 32'd5);
    check("flat_period", 32'(meas_period), 32'd8);

    // Lock, then jump 4->9
    do_reset();
    t = 2; up = 1;
    for (int i = 0; i < 15; i++) begin drive(1'b1, 8'(t)); tri_next(t, up, 2, 5); end
    check("pre_jump_locked", 32'(locked), 32'd1);
    drive(1'b1, 8'd9);
    check("jump_step_err", 32'(step_err), 32'd1);
    check("jump_locked", 32'(locked), 32'd0);
    check("jump_no_mv", 32'(meas_valid), 32'd0);
    drive(1'b1, 8'd8);
    check("jump_err_pulse", 32'(step_err), 32'd0);
    cur = 8; up = 0;
    for (int i = 0; i < 30; i++) begin tri_next(cur, up, 2, 8); drive(1'b1, 8'(cur)); end

    // rst mid falling slope, then relock
    drive(1'b1, 8'd6);
    drive(1'b1, 8'd5);
    do_reset();
    t = 4; up = 0;
    for (int i = 0; i < 20; i++) begin drive(1'b1, 8'(t)); tri_next(t, up, 2, 5); end

    // Random walk with flats, gaps and occasional jumps
    do_reset();
    cur = 100;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        drive(1'b0, 8'($urandom_range(0, 255)));
      end else begin
        if (r < 22) cur = int'($urandom_range(0, 255));
        else if (r < 40) cur = cur;
        else if ((r % 2) == 0) cur = (cur < 255) ? cur + 1 : cur - 1;
        else cur = (cur > 0) ? cur - 1 : cur + 1;
        if (i % 97 < 50) begin
          if (r >= 40) cur = (cur < 255) ? cur + ((r % 2 == 0) ? 0 : 0) : cur;
        end
        drive(1'b1, 8'(cur));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
